// File: rtl/load_store_unit_if.sv
// Request, data-memory and writeback bundle between EX/MEM, the load/store unit and MEM/WB.
// The slave modport is the load/store unit's view; the master modport is the pipeline/memory side.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        stall;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        err;
  logic [31:0] err_addr;

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, req_rd, mem_rdata,
    output stall, mem_we, mem_addr, mem_wdata, wb_valid, wb_data, wb_rd, err, err_addr
  );

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, req_rd, mem_rdata,
    input  stall, mem_we, mem_addr, mem_wdata, wb_valid, wb_data, wb_rd, err, err_addr
  );
endinterface

// File: rtl/load_store_unit.sv
// MEM-stage load/store front end: loads and word stores take 1 cycle (load data registered to WB);
// sub-word stores read-modify-write over 2 cycles, holding the pipeline with stall for the first.
module load_store_unit #(
  parameter int WORDS_LOG2 = 10
) (
  input logic              clk,
  input logic              rst,
  load_store_unit_if.slave lsu
);
  typedef enum logic {IDLE, MERGE} state_t;

  state_t                  state_q, state_d;
  logic [WORDS_LOG2-1:0]   idx_q, idx_d;
  logic [31:0]             old_q, old_d;
  logic [1:0]              lane_q, lane_d;
  logic                    half_q, half_d;
  logic [15:0]             wdat_q, wdat_d;
  logic                    wb_valid_q, wb_valid_d;
  logic [31:0]             wb_data_q, wb_data_d;
  logic [4:0]              wb_rd_q, wb_rd_d;
  logic                    err_q, err_d;
  logic [31:0]             err_addr_q, err_addr_d;

  logic                    bad;
  logic [31:0]             shifted;
  logic [31:0]             ld_data;
  logic [31:0]             merged;
  logic                    stall;
  logic                    mem_we;
  logic [31:0]             mem_addr;
  logic [31:0]             mem_wdata;

  assign bad = (lsu.req_size == 2'b11)
             || (lsu.req_size == 2'b01 && lsu.req_addr[0])
             || (lsu.req_size == 2'b10 && lsu.req_addr[1:0] != 2'b00)
             || (|lsu.req_addr[31:WORDS_LOG2+2]);

  // Little-endian lane select: shift the addressed byte/half down to bit 0.
  assign shifted = lsu.mem_rdata >> {lsu.req_addr[1:0], 3'b000};

  always_comb begin
    ld_data = lsu.mem_rdata;
    case (lsu.req_size)
      2'b00:   ld_data = lsu.req_unsigned ? {24'h0, shifted[7:0]}
                                          : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   ld_data = lsu.req_unsigned ? {16'h0, shifted[15:0]}
                                          : {{16{shifted[15]}}, shifted[15:0]};
      default: ld_data = lsu.mem_rdata;
    endcase
  end

  always_comb begin
    merged = old_q;
    if (half_q) begin
      if (lane_q[1]) merged[31:16] = wdat_q;
      else           merged[15:0]  = wdat_q;
    end else begin
      case (lane_q)
        2'd0:    merged[7:0]   = wdat_q[7:0];
        2'd1:    merged[15:8]  = wdat_q[7:0];
        2'd2:    merged[23:16] = wdat_q[7:0];
        default: merged[31:24] = wdat_q[7:0];
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    old_d      = old_q;
    lane_d     = lane_q;
    half_d     = half_q;
    wdat_d     = wdat_q;
    wb_valid_d = 1'b0;
    wb_data_d  = wb_data_q;
    wb_rd_d    = wb_rd_q;
    err_d      = 1'b0;
    err_addr_d = err_addr_q;
    stall      = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = {{(32-WORDS_LOG2){1'b0}}, lsu.req_addr[WORDS_LOG2+1:2]};
    mem_wdata  = lsu.req_wdata;
    case (state_q)
      IDLE: begin
        if (lsu.req_valid) begin
          if (bad) begin
            err_d      = 1'b1;
            err_addr_d = lsu.req_addr;
          end else if (lsu.req_write) begin
            if (lsu.req_size == 2'b10) begin
              mem_we = 1'b1;
            end else begin
              // Capture the old word now so the write cycle never depends on a same-cycle read.
              stall   = 1'b1;
              idx_d   = lsu.req_addr[WORDS_LOG2+1:2];
              old_d   = lsu.mem_rdata;
              lane_d  = lsu.req_addr[1:0];
              half_d  = lsu.req_size[0];
              wdat_d  = lsu.req_wdata[15:0];
              state_d = MERGE;
            end
          end else begin
            wb_valid_d = 1'b1;
            wb_data_d  = ld_data;
            wb_rd_d    = lsu.req_rd;
          end
        end
      end
      default: begin
        mem_we    = 1'b1;
        mem_addr  = {{(32-WORDS_LOG2){1'b0}}, idx_q};
        mem_wdata = merged;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      old_q      <= '0;
      lane_q     <= '0;
      half_q     <= 1'b0;
      wdat_q     <= '0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      wb_rd_q    <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      old_q      <= old_d;
      lane_q     <= lane_d;
      half_q     <= half_d;
      wdat_q     <= wdat_d;
      wb_valid_q <= wb_valid_d;
      wb_data_q  <= wb_data_d;
      wb_rd_q    <= wb_rd_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign lsu.stall     = stall;
  assign lsu.mem_we    = mem_we;
  assign lsu.mem_addr  = mem_addr;
  assign lsu.mem_wdata = mem_wdata;
  assign lsu.wb_valid  = wb_valid_q;
  assign lsu.wb_data   = wb_data_q;
  assign lsu.wb_rd     = wb_rd_q;
  assign lsu.err       = err_q;
  assign lsu.err_addr  = err_addr_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: behavioural 1024x32 memory, directed requests, and queue-based
// scoreboards for writeback results and error pulses checked by an independent monitor.
module tb_load_store_unit;
  logic clk;
  logic rst;
  load_store_unit_if ifc();

  load_store_unit #(.WORDS_LOG2(10)) dut (.clk(clk), .rst(rst), .lsu(ifc));

  logic [31:0] mem [1024];
  int          writes;
  int          checks;
  int          errors;
  int          stalls;
  logic [36:0] wbq [$];
  logic [31:0] errq [$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign ifc.mem_rdata = mem[ifc.mem_addr[9:0]];

  always @(posedge clk) begin
    if (ifc.mem_we) begin
      mem[ifc.mem_addr[9:0]] <= ifc.mem_wdata;
      writes <= writes + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboards whenever the DUT presents a result or an error pulse.
  always @(negedge clk) begin
    logic [36:0] e;
    if (ifc.wb_valid) begin
      if (wbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wb_unexpected: got rd=%0d data=%h expected no writeback", ifc.wb_rd, ifc.wb_data);
      end else begin
        e = wbq.pop_front();
        chk("wb_data", ifc.wb_data, e[31:0]);
        chk("wb_rd", {27'h0, ifc.wb_rd}, {27'h0, e[36:32]});
      end
    end
    if (ifc.err) begin
      if (errq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL err_unexpected: got err=1 addr=%h expected err=0", ifc.err_addr);
      end else begin
        chk("err_addr", ifc.err_addr, errq.pop_front());
      end
    end
  end

  task automatic issue(input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd);
    logic st;
    ifc.req_valid    = 1'b1;
    ifc.req_write    = w;
    ifc.req_size     = sz;
    ifc.req_unsigned = u;
    ifc.req_addr     = a;
    ifc.req_wdata    = d;
    ifc.req_rd       = rd;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      st = ifc.stall;
      if (st) stalls++;
      @(posedge clk);
      #1;
      if (!st) break;
      if (n == 3) begin
        checks++;
        errors++;
        $display("FAIL stall_timeout: got stall=1 for 4 cycles expected release");
      end
    end
    ifc.req_valid = 1'b0;
  endtask

  task automatic ld(input logic [1:0] sz, input logic u, input logic [31:0] a,
                    input logic [4:0] rd, input logic [31:0] exp);
    wbq.push_back({rd, exp});
    issue(1'b0, sz, u, a, 32'h0, rd);
  endtask

  task automatic st(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    issue(1'b1, sz, 1'b0, a, d, 5'd0);
  endtask

  task automatic bad(input logic w, input logic [1:0] sz, input logic [31:0] a);
    errq.push_back(a);
    issue(w, sz, 1'b0, a, 32'h1111, 5'd9);
  endtask

  initial begin
    int wr0;
    checks = 0;
    errors = 0;
    stalls = 0;
    writes = 0;
    rst = 1'b0;
    ifc.req_valid = 1'b0;
    ifc.req_write = 1'b0;
    ifc.req_size = 2'b10;
    ifc.req_unsigned = 1'b0;
    ifc.req_addr = 32'h0;
    ifc.req_wdata = 32'h0;
    ifc.req_rd = 5'd0;
    #12;
    chk("rst_wb_valid", {31'h0, ifc.wb_valid}, 32'h0);
    chk("rst_wb_data", ifc.wb_data, 32'h0);
    chk("rst_wb_rd", {27'h0, ifc.wb_rd}, 32'h0);
    chk("rst_err", {31'h0, ifc.err}, 32'h0);
    chk("rst_err_addr", ifc.err_addr, 32'h0);
    chk("rst_stall", {31'h0, ifc.stall}, 32'h0);
    chk("rst_mem_we", {31'h0, ifc.mem_we}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    st(2'b10, 32'h80, 32'h00000005);
    ld(2'b10, 1'b0, 32'h80, 5'd3, 32'h00000005);

    st(2'b10, 32'h40, 32'h8899AABB);
    ld(2'b00, 1'b0, 32'h43, 5'd1, 32'hFFFFFF88);
    ld(2'b00, 1'b1, 32'h43, 5'd2, 32'h00000088);
    ld(2'b01, 1'b0, 32'h42, 5'd4, 32'hFFFF8899);
    ld(2'b01, 1'b1, 32'h40, 5'd5, 32'h0000AABB);
    ld(2'b00, 1'b0, 32'h40, 5'd6, 32'hFFFFFFBB);
    ld(2'b00, 1'b1, 32'h41, 5'd0, 32'h000000AA);
    ld(2'b10, 1'b0, 32'h40, 5'd7, 32'h8899AABB);

    st(2'b10, 32'h40, 32'h11223344);
    stalls = 0;
    st(2'b00, 32'h41, 32'h000000EE);
    chk("sb_stalls", stalls, 32'd1);
    ld(2'b10, 1'b0, 32'h40, 5'd8, 32'h1122EE44);

    st(2'b10, 32'h40, 32'h11223344);
    stalls = 0;
    st(2'b01, 32'h42, 32'h0000BEEF);
    st(2'b10, 32'h44, 32'hCAFEF00D);
    chk("sh_sw_stalls", stalls, 32'd1);
    ld(2'b10, 1'b0, 32'h40, 5'd10, 32'hBEEF3344);
    ld(2'b10, 1'b0, 32'h44, 5'd11, 32'hCAFEF00D);
    st(2'b00, 32'h47, 32'h0000005A);
    st(2'b01, 32'h44, 32'hFFFF1234);
    ld(2'b10, 1'b0, 32'h44, 5'd12, 32'h5AFE1234);

    wr0 = writes;
    stalls = 0;
    bad(1'b0, 2'b10, 32'h42);
    bad(1'b1, 2'b01, 32'h41);
    bad(1'b0, 2'b11, 32'h8);
    bad(1'b1, 2'b00, 32'h1003);
    bad(1'b0, 2'b10, 32'h1000);
    chk("bad_writes", writes - wr0, 32'd0);
    chk("bad_stalls", stalls, 32'd0);
    chk("err_addr_last", ifc.err_addr, 32'h1000);
    @(posedge clk);
    #1;
    chk("err_addr_hold", ifc.err_addr, 32'h1000);

    st(2'b10, 32'h190, 32'h55667788);
    wr0 = writes;
    ifc.req_valid = 1'b1;
    ifc.req_write = 1'b1;
    ifc.req_size = 2'b00;
    ifc.req_addr = 32'h191;
    ifc.req_wdata = 32'h99;
    @(posedge clk);
    #1;
    chk("merge_stall", {31'h0, ifc.stall}, 32'h0);
    rst = 1'b0;
    ifc.req_valid = 1'b0;
    #1;
    chk("mrst_mem_we", {31'h0, ifc.mem_we}, 32'h0);
    chk("mrst_stall", {31'h0, ifc.stall}, 32'h0);
    chk("mrst_wb_valid", {31'h0, ifc.wb_valid}, 32'h0);
    chk("mrst_err", {31'h0, ifc.err}, 32'h0);
    chk("mrst_err_addr", ifc.err_addr, 32'h0);
    chk("mrst_wb_data", ifc.wb_data, 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("mrst_writes", writes - wr0, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    ld(2'b10, 1'b0, 32'h190, 5'd13, 32'h55667788);

    repeat (3) @(posedge clk);
    chk("wbq_drained", wbq.size(), 32'd0);
    chk("errq_drained", errq.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
